// File: rtl/emc_pkg.sv
// Shared definitions for the EMC axis pulse scheduler: axis indices,
// default timing parameters, scheduler state encoding and magnitude width.
package emc_pkg;

  localparam int AX_X = 0;
  localparam int AX_Y = 1;
  localparam int AX_A = 2;
  localparam int AX_B = 3;

  localparam int TICK_DIV_DEF  = 100;
  localparam int SLOTS_DEF     = 1000;
  localparam int STEP_HIGH_DEF = 20;

  // 17 bits so that |-32768| is representable
  localparam int MAG_W = 17;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_t;

endpackage

// File: rtl/emc_axis_dda.sv
// One axis of the scheduler: converts a signed pulse word into a clamped
// magnitude and direction, spreads the magnitude across the period with a
// Bresenham accumulator and stretches each fire into a fixed-width step.
module emc_axis_dda
  import emc_pkg::*;
#(
  parameter int SLOTS     = SLOTS_DEF,
  parameter int STEP_HIGH = STEP_HIGH_DEF
) (
  input  logic               clk_100M,
  input  logic               n_rst,
  input  logic               load,
  input  logic               load_vld,
  input  logic               acc_en,
  input  logic signed [15:0] cmd,
  output logic               step,
  output logic               dir,
  output logic               clamp_hit
);

  localparam int ACC_W = MAG_W + 1;
  localparam int CNT_W = $clog2(STEP_HIGH + 1);
  localparam logic [MAG_W-1:0] SLOTS_M = MAG_W'(SLOTS);
  localparam logic [ACC_W-1:0] SLOTS_A = ACC_W'(SLOTS);
  localparam logic [CNT_W-1:0] STEP_W  = CNT_W'(STEP_HIGH);

  // Two's-complement magnitude, widened first so -32768 maps to 32768
  function automatic logic [MAG_W-1:0] abs_mag(input logic signed [15:0] w);
    logic [MAG_W-1:0] u;
    u = {w[15], w};
    return w[15] ? (~u + 17'd1) : u;
  endfunction

  // Saturate a magnitude to the number of slots in one period
  function automatic logic [MAG_W-1:0] sat_mag(input logic [MAG_W-1:0] m);
    return (m > SLOTS_M) ? SLOTS_M : m;
  endfunction

  logic [MAG_W-1:0] mag_raw;
  logic [MAG_W-1:0] mag_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_n;
  logic [CNT_W-1:0] cnt_q;
  logic             fire;

  assign mag_raw   = abs_mag(cmd);
  assign clamp_hit = load & load_vld & (mag_raw > SLOTS_M);
  assign acc_n     = acc_q + {1'b0, mag_q};
  assign fire      = acc_en & (acc_n >= SLOTS_A);
  assign step      = (cnt_q != '0);

  // Active command, accumulator and step-width counter
  always_ff @(posedge clk_100M or negedge n_rst) begin
    if (!n_rst) begin
      mag_q <= '0;
      dir   <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      if (load) begin
        acc_q <= '0;
        if (load_vld) begin
          mag_q <= sat_mag(mag_raw);
          dir   <= cmd[15];
        end else begin
          mag_q <= '0;
        end
      end else if (acc_en) begin
        acc_q <= fire ? (acc_n - SLOTS_A) : acc_n;
      end

      if (fire)
        cnt_q <= STEP_W;
      else if (cnt_q != '0)
        cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/emc_axis_pulse_sched.sv
// Per-period axis pulse scheduler: captures MCU frames into a shadow
// buffer, releases them at each period boundary, and drives four DDA
// step generators. Sticky status flags report underrun, overrun and clamp.
module emc_axis_pulse_sched
  import emc_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int SLOTS     = SLOTS_DEF,
  parameter int STEP_HIGH = STEP_HIGH_DEF
) (
  input  logic               clk_100M,
  input  logic               n_rst,
  input  logic               en,
  input  logic               readyFlag,
  input  logic signed [15:0] XPluse,
  input  logic signed [15:0] YPluse,
  input  logic signed [15:0] APluse,
  input  logic signed [15:0] BPluse,
  input  logic               stat_clr,
  output logic [3:0]         step,
  output logic [3:0]         dir,
  output logic               running,
  output logic               period_strobe,
  output logic               underrun,
  output logic               overrun,
  output logic               clamp
);

  localparam int DIV_W  = $clog2(TICK_DIV);
  localparam int TICK_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(TICK_DIV / 2);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SLOTS - 1);

  sched_state_t       state_q, state_d;
  logic               rdy_p0;
  logic               rise;
  logic signed [15:0] in_word [4];
  logic signed [15:0] sh_word [4];
  logic signed [15:0] cmd_sel [4];
  logic               shadow_valid_q;
  logic [DIV_W-1:0]   div_q;
  logic [TICK_W-1:0]  tick_q;
  logic               at_bound;
  logic               load_cyc;
  logic               load_vld;
  logic               acc_en;
  logic [3:0]         clamp_hit;
  logic               underrun_set, overrun_set, clamp_set;

  assign in_word[AX_X] = XPluse;
  assign in_word[AX_Y] = YPluse;
  assign in_word[AX_A] = APluse;
  assign in_word[AX_B] = BPluse;

  assign rise     = readyFlag & ~rdy_p0;
  // A frame arriving on the load cycle bypasses the shadow buffer
  assign load_vld = rise | shadow_valid_q;
  assign acc_en   = running & (div_q == DIV_HALF);

  // Registered readyFlag for edge detection
  always_ff @(posedge clk_100M or negedge n_rst) begin
    if (!n_rst) rdy_p0 <= 1'b0;
    else        rdy_p0 <= readyFlag;
  end

  // Shadow frame words; only meaningful while shadow_valid_q is set
  always_ff @(posedge clk_100M) begin
    if (rise) sh_word <= in_word;
  end

  // Shadow valid: consumed by a load, set by a new frame
  always_ff @(posedge clk_100M or negedge n_rst) begin
    if (!n_rst)        shadow_valid_q <= 1'b0;
    else if (load_cyc) shadow_valid_q <= 1'b0;
    else if (rise)     shadow_valid_q <= 1'b1;
  end

  // Scheduler state register
  always_ff @(posedge clk_100M or negedge n_rst) begin
    if (!n_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: start on a pending frame, stop only at a period boundary
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en && shadow_valid_q) state_d = ST_RUN;
      ST_RUN:  if (at_bound && !en)      state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State-derived controls: running, boundary position and load cycle
  always_comb begin
    running  = (state_q == ST_RUN);
    at_bound = running && (div_q == '0) && (tick_q == '0);
    load_cyc = at_bound && en;
  end

  assign period_strobe = load_cyc;

  // div/tick counters run only while staying in RUN, otherwise held at 0
  always_ff @(posedge clk_100M or negedge n_rst) begin
    if (!n_rst) begin
      div_q  <= '0;
      tick_q <= '0;
    end else if (state_q == ST_RUN && state_d == ST_RUN) begin
      if (div_q == DIV_LAST) begin
        div_q  <= '0;
        tick_q <= (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end else begin
      div_q  <= '0;
      tick_q <= '0;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_axis
    assign cmd_sel[g] = rise ? in_word[g] : sh_word[g];

    emc_axis_dda #(
      .SLOTS     (SLOTS),
      .STEP_HIGH (STEP_HIGH)
    ) u_dda (
      .clk_100M  (clk_100M),
      .n_rst     (n_rst),
      .load      (load_cyc),
      .load_vld  (load_vld),
      .acc_en    (acc_en),
      .cmd       (cmd_sel[g]),
      .step      (step[g]),
      .dir       (dir[g]),
      .clamp_hit (clamp_hit[g])
    );
  end

  assign underrun_set = load_cyc & ~shadow_valid_q & ~rise;
  assign overrun_set  = rise & shadow_valid_q;
  assign clamp_set    = |clamp_hit;

  // Sticky status flags; a set in the same cycle as a clear wins
  always_ff @(posedge clk_100M or negedge n_rst) begin
    if (!n_rst) begin
      underrun <= 1'b0;
      overrun  <= 1'b0;
      clamp    <= 1'b0;
    end else begin
      underrun <= underrun_set | (underrun & ~stat_clr);
      overrun  <= overrun_set  | (overrun  & ~stat_clr);
      clamp    <= clamp_set    | (clamp    & ~stat_clr);
    end
  end

endmodule

// File: tb/tb_emc_axis_pulse_sched.sv
// Directed bench for emc_axis_pulse_sched with TICK_DIV=8, SLOTS=8,
// STEP_HIGH=2 (64-clock period). A negedge monitor tallies step edges,
// per-tick step positions and pulse widths.
module tb_emc_axis_pulse_sched;

  localparam int TICK_DIV  = 8;
  localparam int SLOTS     = 8;
  localparam int STEP_HIGH = 2;
  localparam int PERIOD    = TICK_DIV * SLOTS;

  logic clk_100M = 1'b0;
  always #5 clk_100M = ~clk_100M;

  logic               n_rst, en, readyFlag, stat_clr;
  logic signed [15:0] XPluse, YPluse, APluse, BPluse;
  logic [3:0]         step, dir;
  logic               running, period_strobe, underrun, overrun, clamp;

  int n_vec = 0;
  int n_bad = 0;

  emc_axis_pulse_sched #(
    .TICK_DIV  (TICK_DIV),
    .SLOTS     (SLOTS),
    .STEP_HIGH (STEP_HIGH)
  ) dut (
    .clk_100M      (clk_100M),
    .n_rst         (n_rst),
    .en            (en),
    .readyFlag     (readyFlag),
    .XPluse        (XPluse),
    .YPluse        (YPluse),
    .APluse        (APluse),
    .BPluse        (BPluse),
    .stat_clr      (stat_clr),
    .step          (step),
    .dir           (dir),
    .running       (running),
    .period_strobe (period_strobe),
    .underrun      (underrun),
    .overrun       (overrun),
    .clamp         (clamp)
  );

  // Monitor state
  int         rise_cnt [4] = '{default: 0};
  logic [7:0] cur_mask [4] = '{default: 8'h00};
  logic [7:0] last_mask[4] = '{default: 8'h00};
  int         hi_len   [4] = '{default: 0};
  logic [3:0] prev_step    = 4'b0;
  int         pos          = 0;
  int         wid_err      = 0;
  int         strobe_cnt   = 0;

  always @(negedge clk_100M) begin
    if (!n_rst) begin
      prev_step = 4'b0;
      for (int i = 0; i < 4; i++) hi_len[i] = 0;
    end else begin
      if (period_strobe) begin
        strobe_cnt++;
        for (int i = 0; i < 4; i++) begin
          last_mask[i] = cur_mask[i];
          cur_mask[i]  = 8'h00;
        end
        pos = 0;
      end else begin
        pos++;
      end
      for (int i = 0; i < 4; i++) begin
        if (step[i] && !prev_step[i]) begin
          rise_cnt[i]++;
          if (pos < PERIOD) cur_mask[i][pos / TICK_DIV] = 1'b1;
        end
        if (step[i]) begin
          hi_len[i]++;
        end else if (prev_step[i]) begin
          if (hi_len[i] != STEP_HIGH) wid_err++;
          hi_len[i] = 0;
        end
      end
      prev_step = step;
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_100M);
    #1;
  endtask

  task automatic send_frame(input logic signed [15:0] x, input logic signed [15:0] y,
                            input logic signed [15:0] a, input logic signed [15:0] b);
    XPluse    = x;
    YPluse    = y;
    APluse    = a;
    BPluse    = b;
    readyFlag = 1'b1;
    cyc(1);
    readyFlag = 1'b0;
    cyc(1);
  endtask

  task automatic wait_strobe(input int lim);
    int k;
    k = 0;
    while (!period_strobe && k < lim) begin
      cyc(1);
      k++;
    end
    check_vec("strobe_seen", {31'b0, period_strobe}, 32'd1);
  endtask

  task automatic pulse_clr();
    stat_clr = 1'b1;
    cyc(1);
    stat_clr = 1'b0;
  endtask

  int s0, x0, a0, b0, r0;

  initial begin
    n_rst     = 1'b0;
    en        = 1'b0;
    readyFlag = 1'b0;
    stat_clr  = 1'b0;
    XPluse    = '0;
    YPluse    = '0;
    APluse    = '0;
    BPluse    = '0;

    // Reset state
    cyc(3);
    check_vec("rst_step", {28'b0, step}, 32'h0);
    check_vec("rst_dir", {28'b0, dir}, 32'h0);
    check_vec("rst_ctl", {28'b0, running, period_strobe, 2'b0}, 32'h0);
    check_vec("rst_flags", {29'b0, underrun, overrun, clamp}, 32'h0);
    n_rst = 1'b1;
    cyc(2);
    check_vec("idle_running", {31'b0, running}, 32'd0);

    // 1: X=2, Y=-8, A=0, B=5
    en = 1'b1;
    send_frame(16'sd2, -16'sd8, 16'sd0, 16'sd5);
    wait_strobe(10);
    s0 = strobe_cnt;
    cyc(10);
    check_vec("t1_dir", {28'b0, dir}, 32'h2);
    cyc(53);
    check_vec("t1_one_strobe", strobe_cnt - s0, 32'd1);
    cyc(1);
    check_vec("t1_period_len", {31'b0, period_strobe}, 32'd1);
    cyc(1);
    check_vec("t1_mask_x", {24'b0, last_mask[0]}, 32'h88);
    check_vec("t1_mask_y", {24'b0, last_mask[1]}, 32'hFF);
    check_vec("t1_mask_a", {24'b0, last_mask[2]}, 32'h00);
    check_vec("t1_mask_b", {24'b0, last_mask[3]}, 32'hDA);

    // 2: no further frame -> underrun, steps stop, dir holds
    check_vec("t2_underrun", {31'b0, underrun}, 32'd1);
    check_vec("t2_dir_hold", {28'b0, dir}, 32'h2);
    r0 = rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3];
    cyc(64);
    check_vec("t2_no_steps", rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3] - r0, 32'd0);
    pulse_clr();
    check_vec("t2_clr", {31'b0, underrun}, 32'd0);
    en = 1'b0;
    cyc(64);
    check_vec("t2_idle", {31'b0, running}, 32'd0);
    check_vec("t2_no_underrun_off", {31'b0, underrun}, 32'd0);

    // 3: two frames before the first boundary -> overrun, second wins
    send_frame(16'sd3, 16'sd0, 16'sd0, 16'sd0);
    send_frame(16'sd6, 16'sd0, 16'sd0, 16'sd0);
    check_vec("t3_overrun", {31'b0, overrun}, 32'd1);
    en = 1'b1;
    wait_strobe(10);
    x0 = rise_cnt[0];
    cyc(64);
    check_vec("t3_x_steps", rise_cnt[0] - x0, 32'd6);
    cyc(1);
    pulse_clr();
    check_vec("t3_flags_clr", {29'b0, underrun, overrun, clamp}, 32'h0);

    // 4: X=-32768 clamps to SLOTS, negative direction
    send_frame(16'sh8000, 16'sd0, 16'sd0, 16'sd0);
    wait_strobe(80);
    x0 = rise_cnt[0];
    cyc(1);
    check_vec("t4_clamp", {31'b0, clamp}, 32'd1);
    check_vec("t4_dir_x", {31'b0, dir[0]}, 32'd1);
    cyc(63);
    cyc(1);
    check_vec("t4_x_steps", rise_cnt[0] - x0, 32'd8);

    // 5: frame arrives on the load cycle itself
    pulse_clr();
    cyc(62);
    check_vec("t5_at_load", {31'b0, period_strobe}, 32'd1);
    XPluse    = 16'sd4;
    YPluse    = 16'sd0;
    APluse    = -16'sd3;
    BPluse    = 16'sd0;
    readyFlag = 1'b1;
    x0 = rise_cnt[0];
    a0 = rise_cnt[2];
    cyc(1);
    readyFlag = 1'b0;
    check_vec("t5_no_underrun", {31'b0, underrun}, 32'd0);
    check_vec("t5_dir", {28'b0, dir}, 32'h4);
    cyc(63);
    cyc(1);
    check_vec("t5_x_steps", rise_cnt[0] - x0, 32'd4);
    check_vec("t5_a_steps", rise_cnt[2] - a0, 32'd3);
    check_vec("t5_next_underrun", {31'b0, underrun}, 32'd1);

    // 6: drop en mid-period, period completes, then reset mid-step
    send_frame(16'sd0, 16'sd0, 16'sd0, 16'sd8);
    wait_strobe(80);
    b0 = rise_cnt[3];
    cyc(10);
    en = 1'b0;
    cyc(54);
    check_vec("t6_still_run", {31'b0, running}, 32'd1);
    check_vec("t6_no_strobe", {31'b0, period_strobe}, 32'd0);
    check_vec("t6_b_steps", rise_cnt[3] - b0, 32'd8);
    cyc(1);
    check_vec("t6_stopped", {31'b0, running}, 32'd0);
    check_vec("pulse_width_errs", wid_err, 32'd0);

    en = 1'b1;
    send_frame(16'sd0, 16'sd0, 16'sd0, -16'sd100);
    begin
      int k;
      k = 0;
      while (!step[3] && k < 100) begin
        cyc(1);
        k++;
      end
    end
    check_vec("t6_step_seen", {31'b0, step[3]}, 32'd1);
    check_vec("t6_clamp", {31'b0, clamp}, 32'd1);
    check_vec("t6_dir_b", {28'b0, dir}, 32'h8);
    #2;
    n_rst = 1'b0;
    #1;
    check_vec("t6_rst_step", {28'b0, step}, 32'h0);
    check_vec("t6_rst_dir", {28'b0, dir}, 32'h0);
    check_vec("t6_rst_flags", {29'b0, underrun, overrun, clamp}, 32'h0);
    check_vec("t6_rst_ctl", {30'b0, running, period_strobe}, 32'h0);
    cyc(2);
    n_rst = 1'b1;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
